reaction_ctrl: RTL and testbench
================================

// Module: reaction_ctrl
// PURPOSE
//   Game-control FSM for the two-player reaction-time tester; drives machine_state into Timer and consumes its
//   handshakes (signal_start, signal_cleared, signal_overflow, react_time). Runs ROUNDS rounds for player A,
//   then ROUNDS for player B, averages each player's times, compares them, and holds the result for display.
// PARAMETERS
//   ROUNDS    4     rounds per player; power of two, 2..16
//   OVF_TIME  1000  score (ms) recorded for an overflow or a false start; must be <= 1023
// PORTS
//   clk            in   1   1 kHz system clock
//   rstn           in   1   asynchronous active-low reset
//   key_go         in   1   start request; 1-cycle pulse, already debounced
//   key_a          in   1   player A reaction key; 1-cycle pulse, already debounced
//   key_b          in   1   player B reaction key; 1-cycle pulse, already debounced
//   signal_start   in   1   from Timer: random delay elapsed (valid in WAIT)
//   signal_cleared in   1   from Timer: counter is zero (valid in CLR_CNT1/CLR_CNT2)
//   signal_overflow in  1   from Timer: reaction count hit limit (valid in START)
//   react_time     in   10  from Timer: elapsed ms, stable in STORAGE
//   machine_state  out  3   current state, encodings below
//   player         out  1   1 = PLAYER_A, 0 = PLAYER_B
//   led_go         out  1   high only in START
//   round_idx      out  4   completed rounds of current player, 0..ROUNDS-1
//   avg_a, avg_b   out  10  per-player average (ms)
//   winner         out  2   01 = A, 10 = B, 11 = tie, 00 = none
//   result_valid   out  1   averages/winner valid
// BEHAVIOUR
//   States: IDLE=0 WAIT=1 CLR_CNT1=2 START=3 STORAGE=4 CLR_CNT2=5 AVERAGE=6 COMPARE=7. All outputs registered.
//   Reset (async, rstn=0): IDLE, player=A, round_idx=0, sums=0, avg_a/avg_b=0, winner=00, result_valid=0,
//     led_go=0, false_start=0, ovf_flag=0. Reset mid-game discards the game.
//   IDLE:     key_go -> WAIT. Same edge: clear sums, round_idx, flags; result_valid=0; winner=00; player=A.
//   WAIT:     signal_start -> CLR_CNT1. Active player's key seen here sets false_start (sticky for the round).
//   CLR_CNT1: signal_cleared -> START.
//   START:    active player's key -> STORAGE; signal_overflow -> STORAGE with ovf_flag=1; both in the same
//             cycle -> key wins, ovf_flag=0. Other player's key ignored in every state.
//   STORAGE:  one cycle. Score = OVF_TIME if ovf_flag|false_start, else react_time. Add score to active
//             player's sum. Clear flags. -> CLR_CNT2.
//   CLR_CNT2: on signal_cleared: if round_idx<ROUNDS-1 -> round_idx+1, WAIT;
//             else if player=A -> player=B, round_idx=0, WAIT; else -> AVERAGE.
//   AVERAGE:  one cycle; avg_x = sum_x >> log2(ROUNDS) (truncate). -> COMPARE.
//   COMPARE:  one cycle; winner by smaller average, equal -> 11; result_valid=1. -> IDLE.
//   Results (avg, winner, result_valid) hold in IDLE until the next key_go.
//   Sum width: 10+log2(ROUNDS) bits; no overflow possible since each score <= 1023.
//   key_go outside IDLE is ignored. No timeouts; FSM waits indefinitely on Timer handshakes.
// STRUCTURE
//   reaction_pkg (shared with Timer and display): state encodings, PLAYER_A/PLAYER_B, OVF_TIME default.
//   Sub-module score_accum (clear, add_en, score[9:0] -> avg[9:0]), instantiated once per player;
//   FSM and comparator stay in reaction_ctrl.
// TESTING
//   1 Reset mid-START (rstn low 3 cycles) -> machine_state=0, led_go=0, all outputs zero, player=1.
//   2 Full game, ROUNDS=4, Timer model returns A: 200,220,240,260; B: 300x4
//     -> avg_a=230, avg_b=300, winner=01, result_valid=1, machine_state returns to 0.
//   3 A false-starts in round 0 (key_a in WAIT), others 200
//     -> A round 0 scores 1000, avg_a=400; game proceeds without stall.
//   4 signal_overflow in START with no key -> STORAGE, score 1000; key_a and overflow same cycle
//     -> react_time stored.
//   5 Equal times 250 for both players -> winner=11; key_b pressed during A's rounds -> no effect.
//   6 key_go during WAIT/START -> ignored; key_go after result -> result_valid=0, state WAIT, sums cleared.

Source files
------------

// File: rtl/reaction_pkg.sv
// ---------------------------------------------------------------------------
// reaction_pkg
//   Definitions shared by the reaction-time tester blocks (game control, Timer,
//   display): machine_state encodings, player identifiers, the default score
//   used for overflows and false starts, winner codes, and the winner decision.
// ---------------------------------------------------------------------------
package reaction_pkg;

  // machine_state encodings, observed by the Timer and the display
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT     = 3'd1;
  localparam logic [2:0] ST_CLR_CNT1 = 3'd2;
  localparam logic [2:0] ST_START    = 3'd3;
  localparam logic [2:0] ST_STORAGE  = 3'd4;
  localparam logic [2:0] ST_CLR_CNT2 = 3'd5;
  localparam logic [2:0] ST_AVERAGE  = 3'd6;
  localparam logic [2:0] ST_COMPARE  = 3'd7;

  localparam logic PLAYER_A = 1'b1;
  localparam logic PLAYER_B = 1'b0;

  // Score (ms) charged for an overflow or a false start
  localparam int OVF_TIME_DEFAULT = 1000;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Smaller average wins; equal averages are a tie
  function automatic logic [1:0] pick_winner(input logic [9:0] avg_a,
                                             input logic [9:0] avg_b);
    if (avg_a < avg_b)      return WIN_A;
    else if (avg_b < avg_a) return WIN_B;
    else                    return WIN_TIE;
  endfunction

endpackage

// File: rtl/score_accum.sv
// ---------------------------------------------------------------------------
// score_accum
//   Per-player score accumulator. Sums ROUNDS scores and, on request, latches
//   the truncated average sum / ROUNDS.
// Ports
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   clear_i    in   clear the running sum (start of a new game)
//   add_en_i   in   add score_i to the running sum this cycle
//   score_i    in   [9:0] score of the round just finished (ms)
//   avg_en_i   in   latch the average of the current sum into avg_o
//   avg_o      out  [9:0] registered average (ms)
// ---------------------------------------------------------------------------
module score_accum
  import reaction_pkg::*;
#(
  parameter int ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear_i,
  input  logic       add_en_i,
  input  logic [9:0] score_i,
  input  logic       avg_en_i,
  output logic [9:0] avg_o
);

  localparam int SHIFT = $clog2(ROUNDS);
  // Every score fits in 10 bits, so SHIFT extra bits can never overflow
  localparam int SUM_W = 10 + SHIFT;

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [9:0]       avg_q, avg_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i)       sum_d = '0;
    else if (add_en_i) sum_d = sum_q + SUM_W'(score_i);
  end

  // ROUNDS is a power of two, so dropping the low bits is the truncated mean
  always_comb begin
    avg_d = avg_q;
    if (avg_en_i) avg_d = sum_q[SUM_W-1:SHIFT];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_q <= '0;
      avg_q <= '0;
    end else begin
      sum_q <= sum_d;
      avg_q <= avg_d;
    end
  end

  assign avg_o = avg_q;

endmodule

// File: rtl/reaction_ctrl.sv
// ---------------------------------------------------------------------------
// reaction_ctrl
//   Game-control FSM of the two-player reaction-time tester. Drives
//   machine_state into the Timer and follows its handshakes, plays ROUNDS
//   rounds for player A then ROUNDS for player B, averages each player's
//   scores, picks the winner and holds the result until the next key_go.
// Ports
//   clk              in   1 kHz system clock
//   rstn             in   asynchronous active-low reset
//   key_go           in   start request pulse (honoured only in IDLE)
//   key_a, key_b     in   player reaction key pulses
//   signal_start     in   Timer: random delay elapsed (WAIT)
//   signal_cleared   in   Timer: counter is zero (CLR_CNT1 / CLR_CNT2)
//   signal_overflow  in   Timer: reaction count hit its limit (START)
//   react_time       in   [9:0] Timer: elapsed ms, stable in STORAGE
//   machine_state    out  [2:0] current state
//   player           out  1 = player A, 0 = player B
//   led_go           out  high only while in START
//   round_idx        out  [3:0] completed rounds of the current player
//   avg_a, avg_b     out  [9:0] per-player averages (ms)
//   winner           out  [1:0] 01 A, 10 B, 11 tie, 00 none
//   result_valid     out  averages and winner are valid
// ---------------------------------------------------------------------------
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int ROUNDS   = 4,
  parameter int OVF_TIME = OVF_TIME_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_go,
  input  logic       key_a,
  input  logic       key_b,
  input  logic       signal_start,
  input  logic       signal_cleared,
  input  logic       signal_overflow,
  input  logic [9:0] react_time,
  output logic [2:0] machine_state,
  output logic       player,
  output logic       led_go,
  output logic [3:0] round_idx,
  output logic [9:0] avg_a,
  output logic [9:0] avg_b,
  output logic [1:0] winner,
  output logic       result_valid
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [9:0] OVF_SCORE  = 10'(OVF_TIME);

  logic [2:0] state_q, state_d;
  logic       player_q, player_d;
  logic [3:0] round_q, round_d;
  logic       false_q, false_d;
  logic       ovf_q, ovf_d;
  logic [1:0] winner_q, winner_d;
  logic       valid_q, valid_d;
  logic       led_go_q, led_go_d;

  logic       clear_sums;
  logic       add_a, add_b;
  logic       avg_en;
  logic       act_key;
  logic [9:0] score;

  // Only the active player's key matters; the other key is ignored everywhere
  assign act_key = (player_q == PLAYER_A) ? key_a : key_b;

  // A penalised round (overflow or false start) scores the fixed penalty
  assign score = (ovf_q | false_q) ? OVF_SCORE : react_time;

  always_comb begin
    state_d    = state_q;
    player_d   = player_q;
    round_d    = round_q;
    false_d    = false_q;
    ovf_d      = ovf_q;
    winner_d   = winner_q;
    valid_d    = valid_q;
    clear_sums = 1'b0;
    add_a      = 1'b0;
    add_b      = 1'b0;
    avg_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_go) begin
          state_d    = ST_WAIT;
          clear_sums = 1'b1;
          round_d    = '0;
          false_d    = 1'b0;
          ovf_d      = 1'b0;
          valid_d    = 1'b0;
          winner_d   = WIN_NONE;
          player_d   = PLAYER_A;
        end
      end
      ST_WAIT: begin
        // Pressing before the go light is a false start; sticky for the round
        if (act_key)      false_d = 1'b1;
        if (signal_start) state_d = ST_CLR_CNT1;
      end
      ST_CLR_CNT1: begin
        if (signal_cleared) state_d = ST_START;
      end
      ST_START: begin
        // A key in the same cycle as overflow counts as a real reaction
        if (act_key) begin
          state_d = ST_STORAGE;
          ovf_d   = 1'b0;
        end else if (signal_overflow) begin
          state_d = ST_STORAGE;
          ovf_d   = 1'b1;
        end
      end
      ST_STORAGE: begin
        add_a   = (player_q == PLAYER_A);
        add_b   = (player_q == PLAYER_B);
        false_d = 1'b0;
        ovf_d   = 1'b0;
        state_d = ST_CLR_CNT2;
      end
      ST_CLR_CNT2: begin
        if (signal_cleared) begin
          if (round_q < LAST_ROUND) begin
            round_d = round_q + 4'd1;
            state_d = ST_WAIT;
          end else if (player_q == PLAYER_A) begin
            player_d = PLAYER_B;
            round_d  = '0;
            state_d  = ST_WAIT;
          end else begin
            state_d = ST_AVERAGE;
          end
        end
      end
      ST_AVERAGE: begin
        avg_en  = 1'b1;
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        // Averages were latched by the accumulators on the AVERAGE edge
        winner_d = pick_winner(avg_a, avg_b);
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign led_go_d = (state_d == ST_START);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      player_q <= PLAYER_A;
      round_q  <= '0;
      false_q  <= 1'b0;
      ovf_q    <= 1'b0;
      winner_q <= WIN_NONE;
      valid_q  <= 1'b0;
      led_go_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      round_q  <= round_d;
      false_q  <= false_d;
      ovf_q    <= ovf_d;
      winner_q <= winner_d;
      valid_q  <= valid_d;
      led_go_q <= led_go_d;
    end
  end

  score_accum #(.ROUNDS(ROUNDS)) u_accum_a (
    .clk      (clk),
    .rstn     (rstn),
    .clear_i  (clear_sums),
    .add_en_i (add_a),
    .score_i  (score),
    .avg_en_i (avg_en),
    .avg_o    (avg_a)
  );

  score_accum #(.ROUNDS(ROUNDS)) u_accum_b (
    .clk      (clk),
    .rstn     (rstn),
    .clear_i  (clear_sums),
    .add_en_i (add_b),
    .score_i  (score),
    .avg_en_i (avg_en),
    .avg_o    (avg_b)
  );

  assign machine_state = state_q;
  assign player        = player_q;
  assign led_go        = led_go_q;
  assign round_idx     = round_q;
  assign winner        = winner_q;
  assign result_valid  = valid_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reaction_ctrl
//   Bench for reaction_ctrl. A small Timer behaviour is played by tasks; the
//   expected averages and winner come from plain per-round score lists
//   (penalised rounds score 1000, others the reaction time), integer mean
//   and a smaller-wins comparison.
// ---------------------------------------------------------------------------
module tb_reaction_ctrl;

  localparam int ROUNDS = 4;
  localparam int OVF    = 1000;
  localparam int BUDGET = 64;

  // Observable state numbering of the game controller
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_CLR1 = 3'd2, S_START = 3'd3,
                         S_STORE = 3'd4, S_CLR2 = 3'd5;

  // Stimulus masks: {ovf, cleared, start, key_b, key_a, key_go}
  localparam logic [5:0] M_GO = 6'b000001, M_KA = 6'b000010, M_KB = 6'b000100,
                         M_ST = 6'b001000, M_CL = 6'b010000, M_OV = 6'b100000;

  // Round kinds: normal key, false start then key, overflow only, key+overflow
  localparam int K_NORM = 0, K_FALSE = 1, K_OVF = 2, K_BOTH = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_go = 1'b0, key_a = 1'b0, key_b = 1'b0;
  logic       signal_start = 1'b0, signal_cleared = 1'b0, signal_overflow = 1'b0;
  logic [9:0] react_time = '0;
  logic [2:0] machine_state;
  logic       player, led_go, result_valid;
  logic [3:0] round_idx;
  logic [9:0] avg_a, avg_b;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reaction_ctrl #(.ROUNDS(ROUNDS), .OVF_TIME(OVF)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .key_go          (key_go),
    .key_a           (key_a),
    .key_b           (key_b),
    .signal_start    (signal_start),
    .signal_cleared  (signal_cleared),
    .signal_overflow (signal_overflow),
    .react_time      (react_time),
    .machine_state   (machine_state),
    .player          (player),
    .led_go          (led_go),
    .round_idx       (round_idx),
    .avg_a           (avg_a),
    .avg_b           (avg_b),
    .winner          (winner),
    .result_valid    (result_valid)
  );

  // Drive a one-cycle pulse on the selected inputs; returns at the next negedge
  task automatic pulse(input logic [5:0] m);
    {signal_overflow, signal_cleared, signal_start, key_b, key_a, key_go} = m;
    @(negedge clk);
    {signal_overflow, signal_cleared, signal_start, key_b, key_a, key_go} = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Bounded wait; the caller judges the outcome
  task automatic wait_state(input logic [2:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (machine_state === s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One round as the Timer would drive it, for player p (1 = A)
  task automatic play_round(input bit p, input int r, input int rt, input int kind,
                            input bit noise);
    bit ok;
    logic [5:0] act, other;
    act   = p ? M_KA : M_KB;
    other = p ? M_KB : M_KA;
    wait_state(S_WAIT, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL round_wait: state=%0d never reached WAIT", machine_state); end
    n_checks++;
    if (round_idx !== 4'(r) || player !== p) begin
      n_fail++;
      $display("FAIL round_id: round_idx=%0d player=%0b expected %0d/%0b", round_idx, player, r, p);
    end
    if (noise) pulse(other | M_GO);
    if (kind == K_FALSE) pulse(act);
    idle($urandom_range(3, 0));
    pulse(M_ST);
    n_checks++;
    if (machine_state !== S_CLR1) begin n_fail++; $display("FAIL to_clr1: state=%0d expected %0d", machine_state, S_CLR1); end
    idle($urandom_range(3, 0));
    pulse(M_CL);
    n_checks++;
    if (machine_state !== S_START || led_go !== 1'b1) begin
      n_fail++;
      $display("FAIL to_start: state=%0d led_go=%0b expected %0d/1", machine_state, led_go, S_START);
    end
    react_time = 10'(rt);
    if (noise) begin
      pulse(other | M_GO);
      n_checks++;
      if (machine_state !== S_START) begin n_fail++; $display("FAIL start_ignore: state=%0d expected %0d", machine_state, S_START); end
    end
    idle($urandom_range(3, 0));
    case (kind)
      K_OVF:   pulse(M_OV);
      K_BOTH:  pulse(act | M_OV);
      default: pulse(act);
    endcase
    n_checks++;
    if (machine_state !== S_STORE || led_go !== 1'b0) begin
      n_fail++;
      $display("FAIL to_storage: state=%0d led_go=%0b expected %0d/0", machine_state, led_go, S_STORE);
    end
    @(negedge clk);
    n_checks++;
    if (machine_state !== S_CLR2) begin n_fail++; $display("FAIL to_clr2: state=%0d expected %0d", machine_state, S_CLR2); end
    idle($urandom_range(3, 0));
    pulse(M_CL);
  endtask

  // Whole game from IDLE; expected results from the per-round score lists
  task automatic play_game(input int ta[ROUNDS], input int tb[ROUNDS],
                           input int ka[ROUNDS], input int kb[ROUNDS], input bit noise);
    bit ok;
    int sum_a, sum_b, exp_a, exp_b;
    logic [1:0] exp_w;
    wait_state(S_IDLE, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL game_idle: state=%0d never reached IDLE", machine_state); end
    pulse(M_GO);
    n_checks++;
    if (machine_state !== S_WAIT || result_valid !== 1'b0 || winner !== 2'b00 || player !== 1'b1) begin
      n_fail++;
      $display("FAIL game_go: state=%0d valid=%0b winner=%0b player=%0b expected 1/0/00/1",
               machine_state, result_valid, winner, player);
    end
    sum_a = 0;
    sum_b = 0;
    for (int r = 0; r < ROUNDS; r++) begin
      play_round(1'b1, r, ta[r], ka[r], noise);
      sum_a += (ka[r] == K_FALSE || ka[r] == K_OVF) ? OVF : ta[r];
    end
    for (int r = 0; r < ROUNDS; r++) begin
      play_round(1'b0, r, tb[r], kb[r], noise);
      sum_b += (kb[r] == K_FALSE || kb[r] == K_OVF) ? OVF : tb[r];
    end
    exp_a = sum_a / ROUNDS;
    exp_b = sum_b / ROUNDS;
    exp_w = (exp_a < exp_b) ? 2'b01 : (exp_b < exp_a) ? 2'b10 : 2'b11;
    wait_state(S_IDLE, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL game_end: state=%0d never returned to IDLE", machine_state); end
    n_checks++;
    if (avg_a !== 10'(exp_a)) begin n_fail++; $display("FAIL avg_a: got %0d expected %0d", avg_a, exp_a); end
    n_checks++;
    if (avg_b !== 10'(exp_b)) begin n_fail++; $display("FAIL avg_b: got %0d expected %0d", avg_b, exp_b); end
    n_checks++;
    if (winner !== exp_w || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result: winner=%0b valid=%0b expected %0b/1", winner, result_valid, exp_w);
    end
    // Results must hold while idle
    idle(5);
    n_checks++;
    if (machine_state !== S_IDLE || winner !== exp_w || result_valid !== 1'b1 || avg_a !== 10'(exp_a)) begin
      n_fail++;
      $display("FAIL result_hold: state=%0d winner=%0b valid=%0b avg_a=%0d", machine_state, winner,
               result_valid, avg_a);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (machine_state !== S_IDLE || player !== 1'b1 || led_go !== 1'b0 || round_idx !== 4'd0 ||
        avg_a !== 10'd0 || avg_b !== 10'd0 || winner !== 2'b00 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d player=%0b led=%0b round=%0d avg=%0d/%0d win=%0b valid=%0b",
               machine_state, player, led_go, round_idx, avg_a, avg_b, winner, result_valid);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_game;
    int ta[ROUNDS] = '{200, 220, 240, 260};
    int tb[ROUNDS] = '{300, 300, 300, 300};
    int kn[ROUNDS] = '{K_NORM, K_NORM, K_NORM, K_NORM};
    play_game(ta, tb, kn, kn, 1'b0);
  endtask

  task automatic test_reset_mid_game;
    bit ok;
    wait_state(S_IDLE, ok);
    pulse(M_GO);
    pulse(M_ST);
    pulse(M_CL);
    n_checks++;
    if (machine_state !== S_START) begin n_fail++; $display("FAIL rst_setup: state=%0d expected %0d", machine_state, S_START); end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (machine_state !== S_IDLE || led_go !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: state=%0d led_go=%0b expected 0/0", machine_state, led_go);
    end
    idle(3);
    n_checks++;
    if (machine_state !== S_IDLE || player !== 1'b1 || led_go !== 1'b0 || round_idx !== 4'd0 ||
        avg_a !== 10'd0 || avg_b !== 10'd0 || winner !== 2'b00 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: state=%0d player=%0b led=%0b round=%0d avg=%0d/%0d win=%0b valid=%0b",
               machine_state, player, led_go, round_idx, avg_a, avg_b, winner, result_valid);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_false_start;
    int t2[ROUNDS] = '{200, 200, 200, 200};
    int ka[ROUNDS] = '{K_FALSE, K_NORM, K_NORM, K_NORM};
    int kn[ROUNDS] = '{K_NORM, K_NORM, K_NORM, K_NORM};
    play_game(t2, t2, ka, kn, 1'b0);
  endtask

  task automatic test_overflow;
    int ta[ROUNDS] = '{150, 180, 210, 90};
    int tb[ROUNDS] = '{400, 410, 420, 430};
    int ka[ROUNDS] = '{K_OVF, K_BOTH, K_NORM, K_NORM};
    int kb[ROUNDS] = '{K_NORM, K_BOTH, K_NORM, K_OVF};
    play_game(ta, tb, ka, kb, 1'b0);
  endtask

  task automatic test_tie;
    int t2[ROUNDS] = '{250, 250, 250, 250};
    int kn[ROUNDS] = '{K_NORM, K_NORM, K_NORM, K_NORM};
    play_game(t2, t2, kn, kn, 1'b1);
  endtask

  task automatic test_back_to_back;
    int ta[ROUNDS], tb[ROUNDS], ka[ROUNDS], kb[ROUNDS];
    for (int g = 0; g < 6; g++) begin
      for (int r = 0; r < ROUNDS; r++) begin
        ta[r] = $urandom_range(999, 1);
        tb[r] = $urandom_range(999, 1);
        ka[r] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : K_NORM;
        kb[r] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : K_NORM;
      end
      play_game(ta, tb, ka, kb, 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_full_game();
    test_reset_mid_game();
    test_false_start();
    test_overflow();
    test_tie();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
